find_cluster_primaries_v2: RTL and testbench
============================================

// Module: find_cluster_primaries_v2
// PURPOSE
//  Parametrised successor to the GEM S-bit cluster primary finder. Per partition row, flags the first
//  pad of every cluster as a valid primary flag (VPF) and gives its size-1 count. Adds a runtime split
//  mode with chained splitting of long runs, count masking, and a per-row cluster tally with overflow.
//  Sits between the S-bit deserialiser/OR stage and the cluster priority encoder/sorter.
// PARAMETERS
//  MXPADS      1536  total S-bit pads, all rows concatenated; row r = sbits[(r+1)*MXKEYS-1 : r*MXKEYS]
//  MXROWS      8     eta partitions; MXPADS % MXROWS == 0 (elaboration error otherwise)
//  MXKEYS      MXPADS/MXROWS  pads per row (localparam, derived)
//  MXCLSIZE    8     max pads per reported cluster; power of 2, >= 2
//  MXSPLITS    2     max extra VPFs one run may generate in split mode (runs > (MXSPLITS+1)*MXCLSIZE lose their tail)
//  MXCNTBITS   $clog2(MXCLSIZE)  count width (localparam)
//  MXROWCL     8     max clusters per row the downstream sorter accepts
//  NCLBITS     $clog2(MXKEYS+1)  per-row tally width (localparam)
// PORTS
//  clock          in   1                  system clock (40/160 MHz domain)
//  reset_n        in   1                  async active-low reset
//  en             in   1                  pipeline enable; 0 = all registers hold
//  valid_in       in   1                  sbits valid this cycle
//  split_mode     in   1                  1 = split runs longer than MXCLSIZE; sampled with sbits
//  sbits          in   MXPADS             raw S-bits
//  valid_out      out  1                  outputs below valid
//  vpfs           out  MXPADS             primary flags
//  cnts           out  MXPADS*MXCNTBITS   size-1 per pad; key k at [(k+1)*MXCNTBITS-1 : k*MXCNTBITS]
//  row_nclusters  out  MXROWS*NCLBITS     VPF count per row
//  row_overflow   out  MXROWS             row tally > MXROWCL
// BEHAVIOUR
//  - One clock, async active-low reset. Reset clears every register and output to 0 immediately;
//    in-flight data is discarded, first valid_out after release needs a fresh valid_in.
//  - Latency 2 enabled cycles; valid_out, vpfs, cnts, row_* are all aligned.
//  - en=0: no register updates, outputs hold; valid_in/sbits ignored that cycle.
//  - Stage 1 per row, key k, s = row bits, s[-1] and s[>=MXKEYS] read as 0:
//    run(k) = consecutive ones ending at k, counted up to (MXSPLITS+1)*MXCLSIZE+1.
//    vpf(k) = s[k] & (run==1 | (split_mode & run==1+j*MXCLSIZE, j=1..MXSPLITS)).
//    cnt(k) = (consecutive ones in s[k+1..k+MXCLSIZE-1], stopping at first 0) when vpf(k), else 0.
//    Max cnt = MXCLSIZE-1, no wrap. Runs never cross rows; key 0 is start of row.
//  - Split off: one VPF per run, cnt saturates at MXCLSIZE-1 for runs >= MXCLSIZE.
//  - Stage 2: vpfs/cnts re-registered; row_nclusters = popcount(row vpfs), exact, cannot overflow
//    NCLBITS; row_overflow = nclusters > MXROWCL.
//  - valid_in=0 with en=1: stage still loads; data outputs follow sbits, valid_out=0 two cycles later.
// STRUCTURE
//  - Shared package cluster_pkg: MXCLSIZE, MXCNTBITS, MXROWCL, NCLBITS, cnts slice helper function.
//  - Sub-module cluster_row_primaries (one row, stage 1: run/vpf/cnt), instanced MXROWS times;
//    top holds valid pipe, stage-2 regs and popcount tree.
// TESTING (MXPADS=1536, MXROWS=8, MXCLSIZE=8, MXSPLITS=2, MXROWCL=8)
//  1 reset_n low mid-stream with valid data in both stages -> all outputs 0 same cycle; valid_out 0
//    until 2 enabled cycles after next valid_in.
//  2 row0 keys 5..7 set, split=0 -> vpf[5]=1 only, cnt[5]=2, nclusters[0]=1, valid_out 2 cycles later.
//  3 row1 keys 0..19 set (global 192..211): split=0 -> vpf@192, cnt=7; split=1 -> vpf@192,200,208,
//    cnts 7,7,3, nclusters[1]=3.
//  4 row2 keys 0..29 set, split=1 -> VPFs at keys 0,8,16 only (MXSPLITS cap), key 24 not flagged.
//  5 sbits key 191 and 192 set (row edge) -> two VPFs, cnt[191]=0, cnt[192]=0; rows independent.
//  6 row3 alternating 1010... (96 clusters) -> nclusters[3]=96, row_overflow[3]=1; toggle en low
//    3 cycles mid-pipe -> outputs frozen, resume with correct latency.

Source files
------------

// File: rtl/cluster_pkg.sv
// Shared constants and slice helper for the S-bit cluster primary finder.
package cluster_pkg;

  localparam int MXCLSIZE       = 8;
  localparam int MXCNTBITS      = $clog2(MXCLSIZE);
  localparam int MXROWCL        = 8;
  localparam int MXKEYS_DEFAULT = 192;
  localparam int NCLBITS        = $clog2(MXKEYS_DEFAULT + 1);

  // LSB position of key's count field inside a packed cnts vector
  function automatic int cnt_lsb(input int key, input int cntbits);
    return key * cntbits;
  endfunction

endpackage

// File: rtl/cluster_row_primaries.sv
// One partition row, stage 1: run tracking, primary flag and size-1 count per key, registered.
module cluster_row_primaries #(
  parameter int MXKEYS    = 192,
  parameter int MXCLSIZE  = 8,
  parameter int MXSPLITS  = 2,
  parameter int MXCNTBITS = $clog2(MXCLSIZE)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        en,
  input  logic                        split_mode,
  input  logic [MXKEYS-1:0]           sbits,
  output logic [MXKEYS-1:0]           vpf,
  output logic [MXKEYS*MXCNTBITS-1:0] cnt
);
  import cluster_pkg::cnt_lsb;

  // run length saturates one past the last split point so long runs never re-trigger
  localparam int RUNMAX  = (MXSPLITS + 1) * MXCLSIZE + 1;
  localparam int RUNBITS = $clog2(RUNMAX + 1);

  logic [MXKEYS+MXCLSIZE-1:0] s_ext;
  logic [MXKEYS-1:0]          vpf_c;
  logic [MXKEYS*MXCNTBITS-1:0] cnt_c;
  logic [RUNBITS-1:0]         run;
  logic [MXCNTBITS-1:0]       ones;
  logic                       more;
  logic                       split_pt;

  assign s_ext = {{MXCLSIZE{1'b0}}, sbits};

  // Scan the row: run ending at k, primary decision, forward count of trailing ones
  always_comb begin
    vpf_c    = '0;
    cnt_c    = '0;
    run      = '0;
    ones     = '0;
    more     = 1'b0;
    split_pt = 1'b0;
    for (int k = 0; k < MXKEYS; k++) begin
      if (!s_ext[k]) run = '0;
      else if (run != RUNBITS'(RUNMAX)) run = run + RUNBITS'(1);
      else run = run;
      split_pt = 1'b0;
      for (int j = 1; j <= MXSPLITS; j++) begin
        if (run == RUNBITS'(1 + j * MXCLSIZE)) split_pt = 1'b1;
        else split_pt = split_pt;
      end
      vpf_c[k] = s_ext[k] & ((run == RUNBITS'(1)) | (split_mode & split_pt));
      ones = '0;
      more = 1'b1;
      for (int i = 1; i < MXCLSIZE; i++) begin
        if (more && s_ext[k+i]) ones = ones + MXCNTBITS'(1);
        else more = 1'b0;
      end
      cnt_c[cnt_lsb(k, MXCNTBITS) +: MXCNTBITS] = vpf_c[k] ? ones : '0;
    end
  end

  // Stage-1 register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vpf <= '0;
      cnt <= '0;
    end else if (en) begin
      vpf <= vpf_c;
      cnt <= cnt_c;
    end else begin
      vpf <= vpf;
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/find_cluster_primaries_v2.sv
// Cluster primary finder: per-row VPF/count stage, then re-registered outputs with per-row tallies.
module find_cluster_primaries_v2 #(
  parameter  int MXPADS    = 1536,
  parameter  int MXROWS    = 8,
  parameter  int MXCLSIZE  = cluster_pkg::MXCLSIZE,
  parameter  int MXSPLITS  = 2,
  parameter  int MXROWCL   = cluster_pkg::MXROWCL,
  localparam int MXKEYS    = MXPADS / MXROWS,
  localparam int MXCNTBITS = $clog2(MXCLSIZE),
  localparam int NCLBITS   = $clog2(MXKEYS + 1)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic                          valid_in,
  input  logic                          split_mode,
  input  logic [MXPADS-1:0]             sbits,
  output logic                          valid_out,
  output logic [MXPADS-1:0]             vpfs,
  output logic [MXPADS*MXCNTBITS-1:0]   cnts,
  output logic [MXROWS*NCLBITS-1:0]     row_nclusters,
  output logic [MXROWS-1:0]             row_overflow
);

  if (MXPADS % MXROWS != 0) begin : g_bad_rows
    $error("MXPADS must be a multiple of MXROWS");
  end
  if (MXCLSIZE < 2 || (MXCLSIZE & (MXCLSIZE - 1)) != 0) begin : g_bad_clsize
    $error("MXCLSIZE must be a power of 2 and at least 2");
  end

  logic [MXPADS-1:0]           vpf1;
  logic [MXPADS*MXCNTBITS-1:0] cnt1;
  logic                        valid1;
  logic [MXROWS*NCLBITS-1:0]   ncl_c;
  logic [MXROWS-1:0]           ovf_c;

  for (genvar r = 0; r < MXROWS; r++) begin : g_row
    cluster_row_primaries #(
      .MXKEYS   (MXKEYS),
      .MXCLSIZE (MXCLSIZE),
      .MXSPLITS (MXSPLITS),
      .MXCNTBITS(MXCNTBITS)
    ) u_row (
      .clock     (clock),
      .reset_n   (reset_n),
      .en        (en),
      .split_mode(split_mode),
      .sbits     (sbits[r*MXKEYS +: MXKEYS]),
      .vpf       (vpf1[r*MXKEYS +: MXKEYS]),
      .cnt       (cnt1[r*MXKEYS*MXCNTBITS +: MXKEYS*MXCNTBITS])
    );
  end

  // Per-row popcount of stage-1 flags and overflow against the sorter's capacity
  always_comb begin
    ncl_c = '0;
    ovf_c = '0;
    for (int r = 0; r < MXROWS; r++) begin
      for (int k = 0; k < MXKEYS; k++) begin
        ncl_c[r*NCLBITS +: NCLBITS] = ncl_c[r*NCLBITS +: NCLBITS] + NCLBITS'(vpf1[r*MXKEYS + k]);
      end
      ovf_c[r] = (ncl_c[r*NCLBITS +: NCLBITS] > NCLBITS'(MXROWCL));
    end
  end

  // Valid pipe and stage-2 output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid1        <= 1'b0;
      valid_out     <= 1'b0;
      vpfs          <= '0;
      cnts          <= '0;
      row_nclusters <= '0;
      row_overflow  <= '0;
    end else if (en) begin
      valid1        <= valid_in;
      valid_out     <= valid1;
      vpfs          <= vpf1;
      cnts          <= cnt1;
      row_nclusters <= ncl_c;
      row_overflow  <= ovf_c;
    end else begin
      valid1        <= valid1;
      valid_out     <= valid_out;
      vpfs          <= vpfs;
      cnts          <= cnts;
      row_nclusters <= row_nclusters;
      row_overflow  <= row_overflow;
    end
  end

endmodule

// File: tb/tb_find_cluster_primaries_v2.sv
// Directed bench for find_cluster_primaries_v2 with hand-computed expectations.
module tb_find_cluster_primaries_v2;

  localparam int MXPADS  = 1536;
  localparam int MXROWS  = 8;
  localparam int CB      = 3;
  localparam int NB      = 8;

  logic                     clock;
  logic                     reset_n;
  logic                     en;
  logic                     valid_in;
  logic                     split_mode;
  logic [MXPADS-1:0]        sbits;
  logic                     valid_out;
  logic [MXPADS-1:0]        vpfs;
  logic [MXPADS*CB-1:0]     cnts;
  logic [MXROWS*NB-1:0]     row_nclusters;
  logic [MXROWS-1:0]        row_overflow;

  logic [MXPADS-1:0]        exp_vpf;
  logic [MXPADS*CB-1:0]     exp_cnts;
  logic [MXROWS*NB-1:0]     exp_ncl;
  logic [MXROWS-1:0]        exp_ovf;

  int errors = 0;
  int checks = 0;

  find_cluster_primaries_v2 dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .en           (en),
    .valid_in     (valid_in),
    .split_mode   (split_mode),
    .sbits        (sbits),
    .valid_out    (valid_out),
    .vpfs         (vpfs),
    .cnts         (cnts),
    .row_nclusters(row_nclusters),
    .row_overflow (row_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_exp();
    exp_vpf  = '0;
    exp_cnts = '0;
    exp_ncl  = '0;
    exp_ovf  = '0;
  endtask

  task automatic add_vpf(input int key, input int cnt);
    exp_vpf[key]          = 1'b1;
    exp_cnts[key*CB +: CB] = CB'(cnt);
  endtask

  task automatic set_ncl(input int row, input int n);
    exp_ncl[row*NB +: NB] = NB'(n);
  endtask

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int fk;
    fk = -1;
    checks++;
    assert (vpfs === exp_vpf) else begin
      errors++;
      for (int k = 0; k < MXPADS; k++) if (fk < 0 && vpfs[k] !== exp_vpf[k]) fk = k;
      $error("FAIL %s_vpfs: key %0d observed=%0b expected=%0b", tag, fk, vpfs[fk], exp_vpf[fk]);
    end
    fk = -1;
    checks++;
    assert (cnts === exp_cnts) else begin
      errors++;
      for (int k = 0; k < MXPADS; k++) if (fk < 0 && cnts[k*CB +: CB] !== exp_cnts[k*CB +: CB]) fk = k;
      $error("FAIL %s_cnts: key %0d observed=%0d expected=%0d", tag, fk,
             cnts[fk*CB +: CB], exp_cnts[fk*CB +: CB]);
    end
    cmp({tag, "_nclusters"}, row_nclusters, exp_ncl);
    cmp({tag, "_overflow"}, 64'(row_overflow), 64'(exp_ovf));
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; valid_in = 1'b0; split_mode = 1'b0; sbits = '0;
    clear_exp();
    tick(); tick();
    check_outputs("reset");
    cmp("reset_valid", 64'(valid_out), 64'd0);
    reset_n = 1'b1;
    tick();

    // Short cluster in row 0, valid for one cycle
    sbits = '0; sbits[7:5] = 3'b111; valid_in = 1'b1; split_mode = 1'b0;
    tick();
    cmp("t2_valid_lat1", 64'(valid_out), 64'd0);
    valid_in = 1'b0;
    tick();
    cmp("t2_valid", 64'(valid_out), 64'd1);
    clear_exp(); add_vpf(5, 2); set_ncl(0, 1);
    check_outputs("t2");
    tick();
    cmp("t2_valid_drop", 64'(valid_out), 64'd0);

    // 20-pad run at start of row 1, split off then on
    sbits = '0; sbits[211:192] = '1; valid_in = 1'b1; split_mode = 1'b0;
    tick(); tick();
    cmp("t3_valid", 64'(valid_out), 64'd1);
    clear_exp(); add_vpf(192, 7); set_ncl(1, 1);
    check_outputs("t3_nosplit");
    split_mode = 1'b1;
    tick(); tick();
    clear_exp(); add_vpf(192, 7); add_vpf(200, 7); add_vpf(208, 3); set_ncl(1, 3);
    check_outputs("t3_split");

    // 30-pad run in row 2: split capped at three primaries
    sbits = '0; sbits[413:384] = '1; split_mode = 1'b1;
    tick(); tick();
    clear_exp(); add_vpf(384, 7); add_vpf(392, 7); add_vpf(400, 7); set_ncl(2, 3);
    check_outputs("t4_split");
    cmp("t4_key24", 64'(vpfs[408]), 64'd0);
    split_mode = 1'b0;
    tick(); tick();
    clear_exp(); add_vpf(384, 7); set_ncl(2, 1);
    check_outputs("t4_nosplit");

    // Adjacent pads straddling the row 0/1 boundary
    sbits = '0; sbits[191] = 1'b1; sbits[192] = 1'b1;
    tick(); tick();
    clear_exp(); add_vpf(191, 0); add_vpf(192, 0); set_ncl(0, 1); set_ncl(1, 1);
    check_outputs("t5_edge");

    // Overflow threshold: 8 clusters in row 4, 9 in row 5
    sbits = '0;
    for (int i = 0; i < 8; i++) sbits[768 + 2*i] = 1'b1;
    for (int i = 0; i < 9; i++) sbits[960 + 2*i] = 1'b1;
    tick(); tick();
    clear_exp();
    for (int i = 0; i < 8; i++) add_vpf(768 + 2*i, 0);
    for (int i = 0; i < 9; i++) add_vpf(960 + 2*i, 0);
    set_ncl(4, 8); set_ncl(5, 9); exp_ovf[5] = 1'b1;
    check_outputs("t7_threshold");

    // Alternating row 3 with a three-cycle enable gap while it is mid-pipe
    sbits = '0;
    for (int i = 0; i < 96; i++) sbits[576 + 2*i] = 1'b1;
    tick();
    en = 1'b0; sbits = '0; valid_in = 1'b0;
    tick(); tick(); tick();
    check_outputs("t6_frozen");
    cmp("t6_frozen_valid", 64'(valid_out), 64'd1);
    en = 1'b1;
    tick();
    clear_exp();
    for (int i = 0; i < 96; i++) add_vpf(576 + 2*i, 0);
    set_ncl(3, 96); exp_ovf[3] = 1'b1;
    check_outputs("t6_alt");
    cmp("t6_valid", 64'(valid_out), 64'd1);
    tick();
    clear_exp();
    check_outputs("t6_after");
    cmp("t6_valid_after", 64'(valid_out), 64'd0);

    // Reset asserted with valid data in both stages
    sbits = '0; sbits[211:192] = '1; split_mode = 1'b1; valid_in = 1'b1;
    tick(); tick();
    cmp("t1_prereset_valid", 64'(valid_out), 64'd1);
    reset_n = 1'b0;
    #1;
    clear_exp();
    check_outputs("t1_reset");
    cmp("t1_reset_valid", 64'(valid_out), 64'd0);
    tick();
    reset_n = 1'b1; valid_in = 1'b0;
    tick(); tick();
    cmp("t1_no_valid", 64'(valid_out), 64'd0);
    valid_in = 1'b1;
    tick();
    cmp("t1_valid_lat1", 64'(valid_out), 64'd0);
    tick();
    cmp("t1_valid", 64'(valid_out), 64'd1);
    clear_exp(); add_vpf(192, 7); add_vpf(200, 7); add_vpf(208, 3); set_ncl(1, 3);
    check_outputs("t1_data");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
